// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the CPU/DMA RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned AddrW = 21;
  localparam int unsigned DataW = 32;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StCpu  = 2'd1;
  localparam state_t StDma  = 2'd2;
  localparam state_t StGap  = 2'd3;

  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnDma
  } owner_e;

  localparam logic       RamCenIdle = 1'b1;
  localparam logic [3:0] RamBenIdle = 4'hF;

endpackage

// File: rtl/ram_arb_if.sv
// Bundles the CPU, DMA and core RAM port signals; master is the arbiter side.
interface ram_arb_if;
  import ram_arb_pkg::*;

  logic             CPU_BCYSTn;
  logic             CPU_CEn;
  logic [AddrW-1:0] CPU_A;
  logic [DataW-1:0] CPU_DI;
  logic             CPU_WEn;
  logic [3:0]       CPU_BEn;
  logic [DataW-1:0] CPU_DO;
  logic             CPU_READYn;

  logic             DMA_REQ;
  logic [AddrW-1:0] DMA_A;
  logic [DataW-1:0] DMA_DI;
  logic             DMA_WE;
  logic [3:0]       DMA_BEn;
  logic             DMA_ACK;
  logic [DataW-1:0] DMA_DO;

  logic [AddrW-1:0] RAM_A;
  logic [DataW-1:0] RAM_DI;
  logic [DataW-1:0] RAM_DO;
  logic             RAM_CEn;
  logic             RAM_WEn;
  logic [3:0]       RAM_BEn;
  logic             RAM_READYn;

  modport master (
    input  CPU_BCYSTn, CPU_CEn, CPU_A, CPU_DI, CPU_WEn, CPU_BEn,
    output CPU_DO, CPU_READYn,
    input  DMA_REQ, DMA_A, DMA_DI, DMA_WE, DMA_BEn,
    output DMA_ACK, DMA_DO,
    output RAM_A, RAM_DI, RAM_CEn, RAM_WEn, RAM_BEn,
    input  RAM_DO, RAM_READYn
  );

  modport slave (
    output CPU_BCYSTn, CPU_CEn, CPU_A, CPU_DI, CPU_WEn, CPU_BEn,
    input  CPU_DO, CPU_READYn,
    output DMA_REQ, DMA_A, DMA_DI, DMA_WE, DMA_BEn,
    input  DMA_ACK, DMA_DO,
    input  RAM_A, RAM_DI, RAM_CEn, RAM_WEn, RAM_BEn,
    output RAM_DO, RAM_READYn
  );

endinterface

// File: rtl/ram_arb_fair.sv
// CPU streak counter: flags when CPU_BURST CPU grants in a row have been made while DMA waited.
module ram_arb_fair #(
  parameter int unsigned CPU_BURST = 4
) (
  input  logic CLK,
  input  logic RES,
  input  logic idle_i,
  input  logic dma_req_i,
  input  logic grant_cpu_i,
  input  logic grant_dma_i,
  output logic burst_hit_o
);

  localparam int unsigned            StreakW  = $clog2(CPU_BURST + 1);
  localparam logic [StreakW-1:0]     BurstMax = StreakW'(CPU_BURST);

  logic [StreakW-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (grant_dma_i) begin
      streak_d = '0;
    end else if (grant_cpu_i && dma_req_i) begin
      if (streak_q != BurstMax) streak_d = streak_q + 1'b1;
    end else if (idle_i && !dma_req_i) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) streak_q <= '0;
    else     streak_q <= streak_d;
  end

  assign burst_hit_o = (streak_q == BurstMax);

endmodule

// File: rtl/ram_arb.sv
// Shares one core RAM port between the V810 CPU and a DMA requester, one access at a time.
// Define RAM_ARB_FAIR_EN to let DMA in after CPU_BURST consecutive contended CPU grants.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned CPU_BURST = 4
) (
  input logic       CLK,
  input logic       RES,
  ram_arb_if.master bus
);

  if (CPU_BURST < 1 || CPU_BURST > 15) begin : g_burst_range
    $error("CPU_BURST must be within 1..15");
  end

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [AddrW-1:0] ram_a_q, ram_a_d;
  logic [DataW-1:0] ram_di_q, ram_di_d;
  logic             ram_cen_q, ram_cen_d;
  logic             ram_wen_q, ram_wen_d;
  logic [3:0]       ram_ben_q, ram_ben_d;
  logic [DataW-1:0] cpu_do_q, cpu_do_d;
  logic             cpu_readyn_q, cpu_readyn_d;
  logic [DataW-1:0] dma_do_q, dma_do_d;
  logic             dma_ack_q, dma_ack_d;
  owner_e           grant;
  logic             prefer_dma;

`ifdef RAM_ARB_FAIR_EN
  logic burst_hit;

  ram_arb_fair #(
    .CPU_BURST(CPU_BURST)
  ) u_fair (
    .CLK        (CLK),
    .RES        (RES),
    .idle_i     (state_q == StIdle),
    .dma_req_i  (bus.DMA_REQ),
    .grant_cpu_i(grant == OwnCpu),
    .grant_dma_i(grant == OwnDma),
    .burst_hit_o(burst_hit)
  );

  assign prefer_dma = burst_hit & bus.DMA_REQ;
`else
  assign prefer_dma = 1'b0;
`endif

  always_comb begin
    grant = OwnNone;
    if (state_q == StIdle) begin
      if (pend_q && !prefer_dma) grant = OwnCpu;
      else if (bus.DMA_REQ)      grant = OwnDma;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    ram_a_d      = ram_a_q;
    ram_di_d     = ram_di_q;
    ram_cen_d    = ram_cen_q;
    ram_wen_d    = ram_wen_q;
    ram_ben_d    = ram_ben_q;
    cpu_do_d     = cpu_do_q;
    dma_do_d     = dma_do_q;
    cpu_readyn_d = 1'b1;
    dma_ack_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant == OwnCpu) begin
          ram_a_d   = bus.CPU_A;
          ram_di_d  = bus.CPU_DI;
          ram_ben_d = bus.CPU_BEn;
          ram_wen_d = bus.CPU_WEn;
          ram_cen_d = 1'b0;
          state_d   = StCpu;
        end else if (grant == OwnDma) begin
          ram_a_d   = bus.DMA_A;
          ram_di_d  = bus.DMA_DI;
          ram_ben_d = bus.DMA_BEn;
          ram_wen_d = ~bus.DMA_WE;
          ram_cen_d = 1'b0;
          state_d   = StDma;
        end
      end
      StCpu, StDma: begin
        if (!bus.RAM_READYn) begin
          // ram_wen_q still holds the access direction here; high means read
          if (state_q == StCpu) begin
            if (ram_wen_q) cpu_do_d = bus.RAM_DO;
            cpu_readyn_d = 1'b0;
            pend_d       = 1'b0;
          end else begin
            if (ram_wen_q) dma_do_d = bus.RAM_DO;
            dma_ack_d = 1'b1;
          end
          ram_cen_d = RamCenIdle;
          ram_wen_d = 1'b1;
          ram_ben_d = RamBenIdle;
          state_d   = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (!bus.CPU_BCYSTn && !bus.CPU_CEn) pend_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      ram_a_q      <= '0;
      ram_di_q     <= '0;
      ram_cen_q    <= RamCenIdle;
      ram_wen_q    <= 1'b1;
      ram_ben_q    <= RamBenIdle;
      cpu_do_q     <= '0;
      cpu_readyn_q <= 1'b1;
      dma_do_q     <= '0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ram_a_q      <= ram_a_d;
      ram_di_q     <= ram_di_d;
      ram_cen_q    <= ram_cen_d;
      ram_wen_q    <= ram_wen_d;
      ram_ben_q    <= ram_ben_d;
      cpu_do_q     <= cpu_do_d;
      cpu_readyn_q <= cpu_readyn_d;
      dma_do_q     <= dma_do_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  assign bus.RAM_A      = ram_a_q;
  assign bus.RAM_DI     = ram_di_q;
  assign bus.RAM_CEn    = ram_cen_q;
  assign bus.RAM_WEn    = ram_wen_q;
  assign bus.RAM_BEn    = ram_ben_q;
  assign bus.CPU_DO     = cpu_do_q;
  assign bus.CPU_READYn = cpu_readyn_q;
  assign bus.DMA_DO     = dma_do_q;
  assign bus.DMA_ACK    = dma_ack_q;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb; fairness expectations follow RAM_ARB_FAIR_EN.
module tb_ram_arb;

  logic CLK = 1'b0;
  logic RES = 1'b1;

  ram_arb_if bus ();

  ram_arb #(
    .CPU_BURST(4)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  bit grants [10];
  int ng;
  int acks;
  logic prev_cen;

  initial begin
    bus.CPU_BCYSTn = 1'b1;
    bus.CPU_CEn    = 1'b1;
    bus.CPU_A      = '0;
    bus.CPU_DI     = '0;
    bus.CPU_WEn    = 1'b1;
    bus.CPU_BEn    = 4'hF;
    bus.DMA_REQ    = 1'b0;
    bus.DMA_A      = '0;
    bus.DMA_DI     = '0;
    bus.DMA_WE     = 1'b0;
    bus.DMA_BEn    = 4'hF;
    bus.RAM_DO     = '0;
    bus.RAM_READYn = 1'b1;

    // Reset values
    step();
    step();
    check("rst_ram_cen",    bus.RAM_CEn,    1);
    check("rst_ram_wen",    bus.RAM_WEn,    1);
    check("rst_ram_ben",    bus.RAM_BEn,    32'hF);
    check("rst_ram_a",      bus.RAM_A,      0);
    check("rst_ram_di",     bus.RAM_DI,     0);
    check("rst_cpu_readyn", bus.CPU_READYn, 1);
    check("rst_cpu_do",     bus.CPU_DO,     0);
    check("rst_dma_ack",    bus.DMA_ACK,    0);
    check("rst_dma_do",     bus.DMA_DO,     0);
    RES = 1'b0;
    step();

    // CPU read, 0-wait: BCYSTn low in cycle b
    bus.CPU_BCYSTn = 1'b0;
    bus.CPU_CEn    = 1'b0;
    bus.CPU_A      = 21'h001234;
    bus.CPU_WEn    = 1'b1;
    bus.CPU_BEn    = 4'h0;
    bus.RAM_DO     = 32'hDEADBEEF;
    bus.RAM_READYn = 1'b0;
    step();  // b+1
    bus.CPU_BCYSTn = 1'b1;
    check("rd_b1_cen", bus.RAM_CEn, 1);
    step();  // b+2
    check("rd_b2_cen",    bus.RAM_CEn,    0);
    check("rd_b2_a",      bus.RAM_A,      32'h001234);
    check("rd_b2_wen",    bus.RAM_WEn,    1);
    check("rd_b2_ben",    bus.RAM_BEn,    0);
    check("rd_b2_readyn", bus.CPU_READYn, 1);
    step();  // b+3
    bus.CPU_CEn = 1'b1;
    check("rd_b3_readyn", bus.CPU_READYn, 0);
    check("rd_b3_do",     bus.CPU_DO,     32'hDEADBEEF);
    check("rd_b3_cen",    bus.RAM_CEn,    1);
    check("rd_b3_ben",    bus.RAM_BEn,    32'hF);
    step();  // b+4
    check("rd_b4_readyn", bus.CPU_READYn, 1);
    check("rd_b4_cen",    bus.RAM_CEn,    1);
    check("rd_b4_do",     bus.CPU_DO,     32'hDEADBEEF);

    // Reset in the middle of a CPU write with RAM stalled
    bus.CPU_BCYSTn = 1'b0;
    bus.CPU_CEn    = 1'b0;
    bus.CPU_A      = 21'h002222;
    bus.CPU_DI     = 32'hCAFEF00D;
    bus.CPU_WEn    = 1'b0;
    bus.RAM_READYn = 1'b1;
    step();
    bus.CPU_BCYSTn = 1'b1;
    step();
    check("mid_cen",  bus.RAM_CEn, 0);
    check("mid_wen",  bus.RAM_WEn, 0);
    check("mid_di",   bus.RAM_DI,  32'hCAFEF00D);
    step();
    check("mid_hold", bus.RAM_CEn, 0);
    RES = 1'b1;
    #1;
    check("mid_rst_cen",    bus.RAM_CEn,    1);
    check("mid_rst_wen",    bus.RAM_WEn,    1);
    check("mid_rst_a",      bus.RAM_A,      0);
    check("mid_rst_di",     bus.RAM_DI,     0);
    check("mid_rst_ben",    bus.RAM_BEn,    32'hF);
    check("mid_rst_cpu_do", bus.CPU_DO,     0);
    bus.RAM_READYn = 1'b0;
    bus.CPU_CEn    = 1'b1;
    bus.CPU_WEn    = 1'b1;
    step();
    step();
    check("mid_rst_readyn", bus.CPU_READYn, 1);
    RES = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_post_readyn", bus.CPU_READYn, 1);
      check("mid_post_cen",    bus.RAM_CEn,    1);
    end

    // Back-to-back DMA reads with REQ held after the first ACK
    bus.DMA_REQ    = 1'b1;
    bus.DMA_A      = 21'h000100;
    bus.DMA_WE     = 1'b0;
    bus.DMA_BEn    = 4'h0;
    bus.RAM_DO     = 32'hA5A50001;
    bus.RAM_READYn = 1'b0;
    step();  // i+1
    check("b2b_cen1", bus.RAM_CEn, 0);
    check("b2b_wen1", bus.RAM_WEn, 1);
    check("b2b_a1",   bus.RAM_A,   32'h000100);
    step();  // GAP
    check("b2b_ack1", bus.DMA_ACK, 1);
    check("b2b_do1",  bus.DMA_DO,  32'hA5A50001);
    check("b2b_gap1", bus.RAM_CEn, 1);
    bus.RAM_DO = 32'hA5A50002;
    step();  // IDLE
    check("b2b_ack_lo", bus.DMA_ACK, 0);
    check("b2b_idle",   bus.RAM_CEn, 1);
    step();
    check("b2b_cen2", bus.RAM_CEn, 0);
    step();
    check("b2b_ack2", bus.DMA_ACK, 1);
    check("b2b_do2",  bus.DMA_DO,  32'hA5A50002);
    bus.DMA_REQ = 1'b0;
    step();
    check("b2b_ack2_lo", bus.DMA_ACK, 0);
    step();
    check("b2b_no_more", bus.RAM_CEn, 1);

    // DMA write with RAM ready delayed 3 cycles
    bus.DMA_REQ    = 1'b1;
    bus.DMA_A      = 21'h1FFFFC;
    bus.DMA_DI     = 32'h01020304;
    bus.DMA_WE     = 1'b1;
    bus.DMA_BEn    = 4'b0011;
    bus.RAM_DO     = 32'h99999999;
    bus.RAM_READYn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("wr_cen", bus.RAM_CEn, 0);
      check("wr_wen", bus.RAM_WEn, 0);
      check("wr_a",   bus.RAM_A,   32'h1FFFFC);
      check("wr_di",  bus.RAM_DI,  32'h01020304);
      check("wr_ben", bus.RAM_BEn, 32'h3);
      check("wr_ack", bus.DMA_ACK, 0);
    end
    bus.RAM_READYn = 1'b0;
    step();
    check("wr_ack_hi", bus.DMA_ACK, 1);
    check("wr_do",     bus.DMA_DO,  32'hA5A50002);
    check("wr_gap",    bus.RAM_CEn, 1);
    bus.DMA_REQ = 1'b0;
    step();
    check("wr_ack_lo", bus.DMA_ACK, 0);
    check("wr_idle",   bus.RAM_CEn, 1);

    // Both pending in the same IDLE cycle: CPU first, then DMA
    bus.CPU_BCYSTn = 1'b0;
    bus.CPU_CEn    = 1'b0;
    bus.CPU_A      = 21'h000040;
    bus.CPU_WEn    = 1'b1;
    bus.RAM_DO     = 32'h11111111;
    bus.DMA_A      = 21'h000080;
    bus.DMA_WE     = 1'b0;
    step();  // IDLE with pending set
    bus.CPU_BCYSTn = 1'b1;
    bus.DMA_REQ    = 1'b1;
    check("both_idle", bus.RAM_CEn, 1);
    step();
    check("both_cpu_cen", bus.RAM_CEn, 0);
    check("both_cpu_a",   bus.RAM_A,   32'h000040);
    step();
    check("both_cpu_rdy", bus.CPU_READYn, 0);
    check("both_cpu_do",  bus.CPU_DO,     32'h11111111);
    check("both_gap",     bus.RAM_CEn,    1);
    bus.CPU_CEn = 1'b1;
    bus.RAM_DO  = 32'h22222222;
    step();
    check("both_idle2", bus.RAM_CEn, 1);
    step();
    check("both_dma_cen", bus.RAM_CEn, 0);
    check("both_dma_a",   bus.RAM_A,   32'h000080);
    step();
    check("both_dma_ack", bus.DMA_ACK, 1);
    check("both_dma_do",  bus.DMA_DO,  32'h22222222);
    check("both_cpu_hold", bus.CPU_DO, 32'h11111111);
    bus.DMA_REQ = 1'b0;
    step();

    // Continuous CPU traffic with DMA_REQ held high
    bus.CPU_BCYSTn = 1'b0;
    bus.CPU_CEn    = 1'b0;
    bus.CPU_A      = 21'h000010;
    bus.DMA_A      = 21'h000020;
    step();
    bus.CPU_BCYSTn = 1'b1;
    bus.DMA_REQ    = 1'b1;
    ng       = 0;
    acks     = 0;
    prev_cen = 1'b1;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      step();
      if (bus.DMA_ACK) acks++;
      if (!bus.RAM_CEn && prev_cen) begin
        grants[ng] = (bus.RAM_A == 21'h000020);
        ng++;
      end
      prev_cen = bus.RAM_CEn;
      bus.CPU_BCYSTn = bus.CPU_READYn;  // V810 restarts in its ready cycle
    end
    check("fair_grant_count", ng, 10);
    for (int k = 0; k < 10; k++) begin
`ifdef RAM_ARB_FAIR_EN
      check($sformatf("fair_grant%0d", k), grants[k], (k % 5 == 4) ? 1 : 0);
`else
      check($sformatf("strict_grant%0d", k), grants[k], 0);
`endif
    end
`ifdef RAM_ARB_FAIR_EN
    check("fair_acks", acks, 1);
`else
    check("strict_acks", acks, 0);
`endif
    bus.CPU_BCYSTn = 1'b1;
    bus.CPU_CEn    = 1'b1;
    bus.DMA_REQ    = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("drain_idle", bus.RAM_CEn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
